ari_right_shift: RTL and testbench

ARI_RIGHT_SHIFT -- requirements
Module: ari_right_shift

---
 rtl/ari_shift_pkg.sv | 8 +
 rtl/ari_right_shift.sv | 52 +++++
 tb/tb_ari_right_shift.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ari_shift_pkg.sv
// ari_shift_pkg: shared width defaults and FSM state encoding for ari_right_shift
package ari_shift_pkg;
  localparam int WIDTH_DEF = 8;
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
  typedef enum logic [1:0] {SHIFT_IDLE, SHIFT_RUN, SHIFT_DONE} state_t;
endpackage

// File: rtl/ari_right_shift.sv
// ari_right_shift: serial arithmetic right shift, one bit per cycle, with sticky and shifted-out bit
module ari_right_shift
  import ari_shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] dout,
  output logic             serial_out,
  output logic             sticky,
  output logic             busy,
  output logic             done
);
  state_t state, state_n;
  logic [CNT_W-1:0] count;
  logic cap;
  assign cap  = start && (state != SHIFT_RUN);
  assign busy = (state == SHIFT_RUN);
  assign done = (state == SHIFT_DONE);
  always_comb begin
    state_n = cap ? ((amount == '0) ? SHIFT_DONE : SHIFT_RUN)
            : (state == SHIFT_RUN) ? ((count == CNT_W'(1)) ? SHIFT_DONE : SHIFT_RUN)
            : SHIFT_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SHIFT_IDLE;
      dout       <= '0;
      count      <= '0;
      serial_out <= 1'b0;
      sticky     <= 1'b0;
    end else begin
      state <= state_n;
      if (cap) begin
        dout       <= din;
        count      <= amount;
        serial_out <= 1'b0;
        sticky     <= 1'b0;
      end else if (state == SHIFT_RUN) begin
        dout       <= {dout[WIDTH-1], dout[WIDTH-1:1]};
        serial_out <= dout[0];
        sticky     <= sticky | dout[0];
        count      <= count - CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_ari_right_shift.sv
// tb_ari_right_shift: randomized and directed checks against an arithmetic reference model
module tb_ari_right_shift;
  localparam int W = 8;
  localparam int CW = 3;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] din = '0, dout;
  logic [CW-1:0] amount = '0;
  logic serial_out, sticky, busy, done;
  int checks = 0, failures = 0;
  logic [W-1:0] e_dout = '0;
  logic e_sticky = 1'b0, e_ser = 1'b0;

  ari_right_shift #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .amount(amount),
    .dout(dout), .serial_out(serial_out), .sticky(sticky), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int a);
    return W'($signed(d) >>> a);
  endfunction

  function automatic logic ref_sticky(input logic [W-1:0] d, input int a);
    logic [W-1:0] m;
    m = W'((1 << a) - 1);
    return (d & m) != '0;
  endfunction

  task automatic run_op(input logic [W-1:0] d, input int a, input bit inj);
    int n, bcnt;
    start = 1'b1; din = d; amount = CW'(a);
    @(posedge clk); #1;
    start = 1'b0; din = $urandom;
    e_dout = ref_shift(d, a);
    e_sticky = ref_sticky(d, a);
    e_ser = (a == 0) ? 1'b0 : d[a-1];
    n = 0; bcnt = 0;
    while (!done && n < 40) begin
      bcnt += int'(busy);
      if (inj && n == 0) begin start = 1'b1; din = 8'h55; amount = CW'($urandom); end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    check("latency", n, a);
    check("busy_cycles", bcnt, a);
    check("dout", dout, e_dout);
    check("sticky", sticky, e_sticky);
    check("serial_out", serial_out, e_ser);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_done", done, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("hold_dout", dout, e_dout);
      check("hold_sticky", sticky, e_sticky);
      check("hold_serial", serial_out, e_ser);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_ser"}, serial_out, 0);
    check({tag, "_sticky"}, sticky, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    #2 check_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_op(8'b10010110, 3, 1'b0);
    check("dir030_dout", dout, 8'b11110010);
    idle(1);
    run_op(8'h17, 2, 1'b0);
    check("dir031_dout", dout, 8'h05);
    idle(1);
    run_op(8'h80, 0, 1'b0);
    idle(2);
    run_op(8'h80, 7, 1'b0);
    check("dir033a_dout", dout, 8'hFF);
    run_op(8'h7F, 7, 1'b0);
    check("dir033b_dout", dout, 8'h00);
    idle(1);
    run_op(8'hC3, 4, 1'b1);
    idle(1);
    start = 1'b1; din = 8'hA5; amount = 3'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    check_zero("abort");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin @(negedge clk); rst_n = 1'b1; #1; end
      check("abort_no_done", done, 1'b0);
      check("abort_no_busy", busy, 1'b0);
    end
    e_dout = '0; e_sticky = 1'b0; e_ser = 1'b0;
    run_op(8'hE9, 5, 1'b0);
    idle(1);
    for (int k = 0; k < 60; k++) begin
      int a;
      a = $urandom_range(0, W - 1);
      run_op(W'($urandom), a, (a >= 2) && ($urandom_range(0, 1) == 1));
      idle($urandom_range(0, 2));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
